// File: rtl/gpu_data_mem_server.sv
// Multi-channel GPU data memory: round-robin arbitration of per-channel read/write
// requesters onto one single-port RAM, with a fixed response latency.
module gpu_data_mem_server #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CHANNELS-1:0]           read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]           read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
    input  logic [NUM_CHANNELS-1:0]           write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
    output logic [NUM_CHANNELS-1:0]           write_ready,
    input  logic                              init_we,
    input  logic [ADDR_BITS-1:0]              init_addr,
    input  logic [DATA_BITS-1:0]              init_data
);

    // state   | meaning
    // IDLE    | requester may be granted when its valid is high
    // WAIT    | granted, counting down the remaining latency
    // RESP    | ready pulse cycle for this requester
    localparam int NUM_REQ  = 2 * NUM_CHANNELS;
    localparam int PTR_BITS = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_BITS = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} req_state_e;

    req_state_e          state_q [NUM_REQ];
    req_state_e          state_d [NUM_REQ];
    logic [CNT_BITS-1:0] cnt_q [NUM_REQ];
    logic [CNT_BITS-1:0] cnt_d [NUM_REQ];
    logic [PTR_BITS-1:0] ptr_q, ptr_d;
    logic [DATA_BITS-1:0] pend_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] pend_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0] read_data_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] read_data_d [NUM_CHANNELS];

    logic [NUM_REQ-1:0]   req_valid;
    logic [PTR_BITS-1:0]  scan_idx;
    logic                 grant_vld;
    logic [PTR_BITS-1:0]  grant_idx;
    logic [ADDR_BITS-1:0] gnt_raddr, gnt_waddr;
    logic [DATA_BITS-1:0] gnt_wdata, ram_rdata;

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    // Even index = read requester, odd index = write requester of the same channel.
    always_comb begin
        req_valid = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            req_valid[2*c]   = read_valid[c];
            req_valid[2*c+1] = write_valid[c];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = PTR_BITS'((int'(ptr_q) + i) % NUM_REQ);
            if (!grant_vld && req_valid[scan_idx] && state_q[scan_idx] == ST_IDLE) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (init_we) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        gnt_raddr = '0;
        gnt_waddr = '0;
        gnt_wdata = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (int'(grant_idx) / 2 == c) begin
                gnt_raddr = read_address[c*ADDR_BITS +: ADDR_BITS];
                gnt_waddr = write_address[c*ADDR_BITS +: ADDR_BITS];
                gnt_wdata = write_data[c*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign ram_rdata = mem[gnt_raddr];

    // Contents survive reset on purpose so preloaded data outlives a kernel abort.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end else if (grant_vld && grant_idx[0]) begin
            mem[gnt_waddr] <= gnt_wdata;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_BITS'(1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (grant_vld && int'(grant_idx) == i) begin
                        if (LATENCY == 1) begin
                            state_d[i] = ST_RESP;
                        end else begin
                            state_d[i] = ST_WAIT;
                            cnt_d[i]   = CNT_BITS'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q[i] == CNT_BITS'(1)) begin
                        state_d[i] = ST_RESP;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
        // Read data is latched at grant and moved to the output on entry to RESP.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            pend_d[c]      = pend_q[c];
            read_data_d[c] = read_data_q[c];
            if (grant_vld && int'(grant_idx) == 2*c) begin
                pend_d[c] = ram_rdata;
            end
            if (state_d[2*c] == ST_RESP) begin
                if (state_q[2*c] == ST_WAIT) begin
                    read_data_d[c] = pend_q[c];
                end else if (state_q[2*c] == ST_IDLE) begin
                    read_data_d[c] = ram_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                pend_q[c]      <= '0;
                read_data_q[c] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                pend_q[c]      <= pend_d[c];
                read_data_q[c] <= read_data_d[c];
            end
        end
    end

    always_comb begin
        read_ready  = '0;
        write_ready = '0;
        read_data   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            read_ready[c]  = (state_q[2*c] == ST_RESP);
            write_ready[c] = (state_q[2*c+1] == ST_RESP);
            read_data[c*DATA_BITS +: DATA_BITS] = read_data_q[c];
        end
    end

endmodule

// File: tb/tb_gpu_data_mem_server.sv
// Bench for gpu_data_mem_server: a LATENCY=2 and a LATENCY=1 instance checked every cycle
// against a timestamp-based model, plus directed literal expectations.
module tb_gpu_data_mem_server;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NC = 4;
    localparam int NR = 2 * NC;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic clk;
    logic rst_n;

    logic [NC-1:0]    rv [2];
    logic [NC*AB-1:0] ra [2];
    logic [NC-1:0]    wv [2];
    logic [NC*AB-1:0] wa [2];
    logic [NC*DB-1:0] wd [2];
    logic             ie [2];
    logic [AB-1:0]    ia [2];
    logic [DB-1:0]    id [2];

    logic [NC-1:0]    rr0, wr0, rr1, wr1;
    logic [NC*DB-1:0] rdat0, rdat1;
    logic [NC-1:0]    rr [2];
    logic [NC-1:0]    wr [2];
    logic [NC*DB-1:0] rdat [2];

    assign rr[0] = rr0;
    assign rr[1] = rr1;
    assign wr[0] = wr0;
    assign wr[1] = wr1;
    assign rdat[0] = rdat0;
    assign rdat[1] = rdat1;

    gpu_data_mem_server #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .read_valid(rv[0]), .read_address(ra[0]), .read_ready(rr0), .read_data(rdat0),
        .write_valid(wv[0]), .write_address(wa[0]), .write_data(wd[0]), .write_ready(wr0),
        .init_we(ie[0]), .init_addr(ia[0]), .init_data(id[0])
    );

    gpu_data_mem_server #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .read_valid(rv[1]), .read_address(ra[1]), .read_ready(rr1), .read_data(rdat1),
        .write_valid(wv[1]), .write_address(wa[1]), .write_data(wd[1]), .write_ready(wr1),
        .init_we(ie[1]), .init_addr(ia[1]), .init_data(id[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each requester remembers the cycle of its ready pulse; it is busy up to and
    // including that cycle.
    int          cyc;
    int          rdy_cyc [2][NR];
    int          ptr_m [2];
    logic [DB-1:0] m_mem [2][256];
    logic [DB-1:0] pend_m [2][NC];
    logic [DB-1:0] exp_rd [2][NC];
    logic [NC-1:0] keep_rd [2];

    int vectors;
    int miscompares;

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ptr_m[k] = 0;
            for (int i = 0; i < NR; i++) rdy_cyc[k][i] = -1;
            for (int c = 0; c < NC; c++) exp_rd[k][c] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (ie[k]) begin
                m_mem[k][ia[k]] = id[k];
            end else begin
                bit got;
                got = 1'b0;
                for (int j = 0; j < NR; j++) begin
                    int i, c;
                    logic v;
                    i = (ptr_m[k] + j) % NR;
                    c = i / 2;
                    v = (i % 2 == 0) ? rv[k][c] : wv[k][c];
                    if (!got && v && rdy_cyc[k][i] < cyc) begin
                        got = 1'b1;
                        rdy_cyc[k][i] = cyc + lat_of(k);
                        if (i % 2 == 0) pend_m[k][c] = m_mem[k][ra[k][c*AB +: AB]];
                        else            m_mem[k][wa[k][c*AB +: AB]] = wd[k][c*DB +: DB];
                        ptr_m[k] = (i + 1) % NR;
                    end
                end
            end
        end
        cyc++;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NC; c++)
                if (rdy_cyc[k][2*c] == cyc) exp_rd[k][c] = pend_m[k][c];
    endtask

    task automatic chk(input string name, input int k, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d ch%0d cyc %0d: got %0h want %0h", name, k, c, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NC; c++) begin
                chk("read_ready", k, c, 32'(rr[k][c]), 32'(rdy_cyc[k][2*c] == cyc));
                chk("write_ready", k, c, 32'(wr[k][c]), 32'(rdy_cyc[k][2*c+1] == cyc));
                chk("read_data", k, c, 32'(rdat[k][c*DB +: DB]), 32'(exp_rd[k][c]));
            end
        end
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge, and
    // the GPU drops any valid whose ready it has just seen.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        compare_all();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NC; c++) begin
                if (rr[k][c] && !keep_rd[k][c]) rv[k][c] = 1'b0;
                if (wr[k][c]) wv[k][c] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = '0;
            wv[k] = '0;
            keep_rd[k] = '0;
        end
        model_reset();
        #1;
        chk("reset_rr", 0, -1, 32'(rr0), 32'd0);
        chk("reset_wr", 0, -1, 32'(wr0), 32'd0);
        chk("reset_rdata", 0, -1, 32'(rdat0), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit seen;
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = '0; ra[k] = '0; wv[k] = '0; wa[k] = '0; wd[k] = '0;
            ie[k] = 1'b0; ia[k] = '0; id[k] = '0; keep_rd[k] = '0;
        end
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Preload mem[0..7] = 1,2,3,4,1,2,3,4; second instance gets 0x77 at addr 5.
        for (int a = 0; a < 8; a++) begin
            ie[0] = 1'b1; ia[0] = AB'(a); id[0] = DB'(a % 4 + 1);
            ie[1] = (a == 0); ia[1] = 8'd5; id[1] = 8'h77;
            tick();
        end
        ie[0] = 1'b0;
        ie[1] = 1'b0;

        // All four channels read 0..3 in one cycle, pointer at 0.
        rv[0] = 4'hF;
        ra[0] = {8'd3, 8'd2, 8'd1, 8'd0};
        tick(); chk("t2_rr_t1", 0, -1, 32'(rr0), 32'h0);
        tick(); chk("t2_rr_t2", 0, -1, 32'(rr0), 32'h1); chk("t2_d0", 0, 0, 32'(rdat0[7:0]), 32'd1);
        tick(); chk("t2_rr_t3", 0, -1, 32'(rr0), 32'h2); chk("t2_d1", 0, 1, 32'(rdat0[15:8]), 32'd2);
        tick(); chk("t2_rr_t4", 0, -1, 32'(rr0), 32'h4); chk("t2_d2", 0, 2, 32'(rdat0[23:16]), 32'd3);
        tick(); chk("t2_rr_t5", 0, -1, 32'(rr0), 32'h8); chk("t2_d3", 0, 3, 32'(rdat0[31:24]), 32'd4);
        tick();

        // Single read of addr 3.
        rv[0][0] = 1'b1; ra[0][7:0] = 8'd3;
        tick(); chk("t1_rr_t1", 0, 0, 32'(rr0[0]), 32'd0);
        tick(); chk("t1_rr_t2", 0, 0, 32'(rr0[0]), 32'd1); chk("t1_data", 0, 0, 32'(rdat0[7:0]), 32'd4);
        tick(); chk("t1_rr_t3", 0, 0, 32'(rr0[0]), 32'd0); chk("t1_hold", 0, 0, 32'(rdat0[7:0]), 32'd4);

        // Write then read of the same address; reset first so the pointer is 0.
        do_reset();
        tick();
        wv[0][1] = 1'b1; wa[0][15:8] = 8'd8; wd[0][15:8] = 8'h2A;
        rv[0][2] = 1'b1; ra[0][23:16] = 8'd8;
        tick(); chk("t3_wr_t1", 0, 1, 32'(wr0[1]), 32'd0);
        tick(); chk("t3_wr_t2", 0, 1, 32'(wr0[1]), 32'd1); chk("t3_rr_t2", 0, 2, 32'(rr0[2]), 32'd0);
        tick(); chk("t3_rr_t3", 0, 2, 32'(rr0[2]), 32'd1); chk("t3_data", 0, 2, 32'(rdat0[23:16]), 32'h2A);
        tick();

        // Preload held three cycles over a pending read of the address it writes.
        rv[0][0] = 1'b1; ra[0][7:0] = 8'd16;
        ie[0] = 1'b1; ia[0] = 8'd16; id[0] = 8'h11;
        tick(); chk("t5_blk1", 0, 0, 32'(rr0[0]), 32'd0);
        id[0] = 8'h22;
        tick(); chk("t5_blk2", 0, 0, 32'(rr0[0]), 32'd0);
        id[0] = 8'h33;
        tick(); chk("t5_blk3", 0, 0, 32'(rr0[0]), 32'd0);
        ie[0] = 1'b0;
        tick(); chk("t5_wait", 0, 0, 32'(rr0[0]), 32'd0);
        tick(); chk("t5_rr", 0, 0, 32'(rr0[0]), 32'd1); chk("t5_data", 0, 0, 32'(rdat0[7:0]), 32'h33);
        tick();

        // Continuous readers on ch0..ch2 must not starve the ch3 write.
        keep_rd[0] = 4'b0111;
        rv[0][2:0] = 3'b111;
        ra[0][23:0] = {8'd2, 8'd1, 8'd0};
        wv[0][3] = 1'b1; wa[0][31:24] = 8'd9; wd[0][31:24] = 8'h5C;
        seen = 1'b0;
        for (int n = 0; n < NR + LAT0 && !seen; n++) begin
            tick();
            if (wr0[3]) seen = 1'b1;
        end
        chk("t4_no_starve", 0, 3, 32'(seen), 32'd1);
        keep_rd[0] = '0;
        repeat (8) tick();
        rv[0][3] = 1'b1; ra[0][31:24] = 8'd9;
        tick(); tick();
        chk("t4_wdata", 0, 3, 32'(rdat0[31:24]), 32'h5C);
        tick();

        // Reset with requests outstanding: nothing pulses afterwards, RAM kept.
        rv[0] = 4'hF;
        ra[0] = {8'd0, 8'd1, 8'd2, 8'd3};
        tick();
        do_reset();
        repeat (6) begin
            tick();
            chk("t6_quiet", 0, -1, 32'({rr0, wr0}), 32'd0);
        end
        rv[0][0] = 1'b1; ra[0][7:0] = 8'd3;
        tick(); tick();
        chk("t6_mem_kept", 0, 0, 32'(rdat0[7:0]), 32'd4);
        tick();

        // LATENCY=1 instance: back-to-back reads on ch0.
        rv[1][0] = 1'b1; ra[1][7:0] = 8'd5; keep_rd[1][0] = 1'b1;
        tick(); chk("t7_rr_t1", 1, 0, 32'(rr1[0]), 32'd1); chk("t7_data", 1, 0, 32'(rdat1[7:0]), 32'h77);
        tick(); chk("t7_rr_t2", 1, 0, 32'(rr1[0]), 32'd0);
        tick(); chk("t7_rr_t3", 1, 0, 32'(rr1[0]), 32'd1);
        keep_rd[1][0] = 1'b0;
        rv[1][0] = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
